// File: rtl/d_store_buffer_pkg.sv
// Shared types for the data-side store buffer: address/width types,
// the buffered store entry and a width-to-byte-count helper.
package d_store_buffer_pkg;

  localparam int DMEM_ADDR_W = 8;

  typedef logic [DMEM_ADDR_W-1:0] DMemAddrT;
  typedef logic [31:0]            word;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } mem_width_t;

  typedef struct packed {
    DMemAddrT   addr;
    mem_width_t width;
    word        data;
  } sb_entry_t;

  // Number of bytes touched by an access of the given width.
  function automatic logic [2:0] width_bytes(input mem_width_t w);
    case (w)
      BYTE:     return 3'd1;
      HALFWORD: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/d_store_buffer_overlap.sv
// Combinational byte-set intersection of two (addr, width) accesses.
// Both byte sets are contiguous runs on a modular address ring, so they
// intersect exactly when one run's start falls inside the other run.
module sb_overlap
  import d_store_buffer_pkg::*;
(
  input  DMemAddrT   a_addr,
  input  mem_width_t a_width,
  input  DMemAddrT   b_addr,
  input  mem_width_t b_width,
  output logic       hit
);

  DMemAddrT b_from_a;
  DMemAddrT a_from_b;

  // Modular distances; subtraction wraps naturally at the top of the space.
  always_comb begin
    b_from_a = b_addr - a_addr;
    a_from_b = a_addr - b_addr;
    hit      = (b_from_a < DMemAddrT'(width_bytes(a_width))) ||
               (a_from_b < DMemAddrT'(width_bytes(b_width)));
  end

endmodule

// File: rtl/d_store_buffer.sv
// Posted-write buffer in front of the data memory. Stores queue in a small
// FIFO and drain one per cycle when no load owns the port; loads bypass the
// queue unless they touch bytes still waiting to be written.
module d_store_buffer
  import d_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st_valid,
  output logic       st_ready,
  input  DMemAddrT   st_addr,
  input  mem_width_t st_width,
  input  word        st_data,
  input  logic       ld_valid,
  input  DMemAddrT   ld_addr,
  input  mem_width_t ld_width,
  input  logic       ld_sign_extend,
  output logic       ld_stall,
  output logic       empty,
  output DMemAddrT   mem_addr,
  output mem_width_t mem_width,
  output logic       mem_sign_extend,
  output logic       mem_write_enable,
  output word        mem_data_in
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic is_empty;
  logic push;
  logic pop;
  logic ld_issue;

  assign full     = (count == DEPTH_C);
  assign is_empty = (count == '0);

  // One overlap checker per slot; empty slots are masked by their valid bit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
    logic raw_hit;
    sb_overlap u_ovl (
      .a_addr  (entries[i].addr),
      .a_width (entries[i].width),
      .b_addr  (ld_addr),
      .b_width (ld_width),
      .hit     (raw_hit)
    );
    assign hit[i] = valid[i] && raw_hit;
  end

  // Port arbitration: an unstalled load wins, else the head drains. While
  // reset is high everything is forced idle so no write escapes at the
  // reset edge.
  always_comb begin
    st_ready         = 1'b1;
    empty            = 1'b1;
    ld_stall         = 1'b0;
    ld_issue         = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    mem_addr         = '0;
    mem_width        = WORD;
    mem_sign_extend  = 1'b0;
    mem_write_enable = 1'b0;
    mem_data_in      = '0;
    if (!reset) begin
      st_ready        = !full;
      empty           = is_empty;
      // Full also stalls the load so the head is guaranteed a drain slot.
      ld_stall        = ld_valid && ((|hit) || full);
      ld_issue        = ld_valid && !ld_stall;
      push            = st_valid && !full;
      mem_addr        = ld_addr;
      mem_width       = ld_width;
      mem_sign_extend = ld_sign_extend;
      if (!ld_issue && !is_empty) begin
        pop              = 1'b1;
        mem_addr         = entries[head].addr;
        mem_width        = entries[head].width;
        mem_sign_extend  = 1'b0;
        mem_write_enable = 1'b1;
        mem_data_in      = entries[head].data;
      end
    end
  end

  // Queue control: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: st_addr, width: st_width, data: st_data};
  end

endmodule
